// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone target among several initiators.
// Grant is held for a whole bus cycle (extended by LOCK); an outstanding counter bounds requests in flight.
//
// Handshake: a request is issued on a cycle where T_STB=1 and T_STALL=0. Every issued request
// retires on exactly one T_ACK or T_ERR cycle. Dropping CYC aborts whatever is still in flight.
module wishbone_rr_arbiter #(
  parameter int NumInitiators  = 4,
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 8,
  parameter int Granularity    = 8,
  parameter int MaxOutstanding = 4,
  localparam int SELWidth      = DataWidth / Granularity,
  localparam int IdxW          = $clog2(NumInitiators),
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [NumInitiators-1:0]              I_CYC,
  input  logic [NumInitiators-1:0]              I_STB,
  input  logic [NumInitiators-1:0]              I_WE,
  input  logic [NumInitiators-1:0]              I_LOCK,
  input  logic [NumInitiators*AddressWidth-1:0] I_ADDR,
  input  logic [NumInitiators*DataWidth-1:0]    I_DAT_ToTarget,
  input  logic [NumInitiators*SELWidth-1:0]     I_SEL,
  output logic [NumInitiators-1:0]              I_STALL,
  output logic [NumInitiators-1:0]              I_ACK,
  output logic [NumInitiators-1:0]              I_ERR,
  output logic [DataWidth-1:0]                  I_DAT_ToInitiator,
  output logic                                  T_CYC,
  output logic                                  T_STB,
  output logic                                  T_WE,
  output logic                                  T_LOCK,
  output logic [AddressWidth-1:0]               T_ADDR,
  output logic [DataWidth-1:0]                  T_DAT_ToTarget,
  output logic [SELWidth-1:0]                   T_SEL,
  input  logic                                  T_STALL,
  input  logic                                  T_ACK,
  input  logic                                  T_ERR,
  input  logic [DataWidth-1:0]                  T_DAT_ToInitiator,
  output logic [NumInitiators-1:0]              Grant,
  output logic [1:0]                            DBG_STATE,
  output logic [CntW-1:0]                       DBG_OUTSTANDING
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          gidx_q, gidx_d;
  logic [NumInitiators-1:0] grant_q, grant_d;
  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [CntW-1:0]          outst_q, outst_d;

  logic [AddressWidth-1:0]  addr_a [NumInitiators];
  logic [DataWidth-1:0]     dat_a  [NumInitiators];
  logic [SELWidth-1:0]      sel_a  [NumInitiators];

  logic                     cyc_g, stb_g, we_g, lock_g;
  logic                     full, stb_issue, accept, retire;
  logic                     any_req;
  logic [IdxW-1:0]          pick;
  logic [NumInitiators-1:0] pick_oh;
  logic [IdxW-1:0]          ptr_adv;
  int                       idx;

  for (genvar k = 0; k < NumInitiators; k++) begin : g_unpack
    assign addr_a[k] = I_ADDR[k*AddressWidth +: AddressWidth];
    assign dat_a[k]  = I_DAT_ToTarget[k*DataWidth +: DataWidth];
    assign sel_a[k]  = I_SEL[k*SELWidth +: SELWidth];
  end

  assign cyc_g  = I_CYC[gidx_q];
  assign stb_g  = I_STB[gidx_q];
  assign we_g   = I_WE[gidx_q];
  assign lock_g = I_LOCK[gidx_q];

  // Full looks only at the registered count, so a same-cycle ACK never unstalls.
  assign full      = (outst_q == CntW'(MaxOutstanding));
  assign stb_issue = (state_q == ST_GRANTED) && stb_g && !full;
  assign accept    = stb_issue && !T_STALL;
  assign retire    = (T_ACK || T_ERR) && (outst_q != '0);
  assign ptr_adv   = (gidx_q == IdxW'(NumInitiators - 1)) ? '0 : gidx_q + 1'b1;

  // First requester at or after the priority pointer, wrapping modulo NumInitiators.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NumInitiators; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NumInitiators) idx = idx - NumInitiators;
      if (!any_req && I_CYC[IdxW'(idx)]) begin
        any_req = 1'b1;
        pick    = IdxW'(idx);
      end
    end
    for (int i = 0; i < NumInitiators; i++) begin
      pick_oh[i] = (pick == IdxW'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gidx_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      outst_q <= outst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    outst_d = outst_q;
    case (state_q)
      ST_IDLE: begin
        outst_d = '0;
        if (any_req) begin
          state_d = ST_GRANTED;
          gidx_d  = pick;
          grant_d = pick_oh;
        end
      end
      ST_GRANTED: begin
        if (!cyc_g) begin
          // CYC drop releases the bus even with requests in flight (abort).
          outst_d = '0;
          if (lock_g) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = ptr_adv;
          end
        end else if (accept && !retire) begin
          outst_d = outst_q + 1'b1;
        end else if (!accept && retire) begin
          outst_d = outst_q - 1'b1;
        end
      end
      ST_LOCKED: begin
        outst_d = '0;
        if (cyc_g) begin
          state_d = ST_GRANTED;
        end else if (!lock_g) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_adv;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        outst_d = '0;
      end
    endcase
  end

  always_comb begin
    T_CYC   = 1'b0;
    T_STB   = 1'b0;
    T_WE    = 1'b0;
    T_LOCK  = 1'b0;
    I_STALL = '1;
    I_ACK   = '0;
    I_ERR   = '0;
    case (state_q)
      ST_GRANTED: begin
        T_CYC           = cyc_g;
        T_STB           = stb_issue;
        T_WE            = we_g;
        T_LOCK          = lock_g;
        I_STALL[gidx_q] = T_STALL || full;
        I_ACK[gidx_q]   = T_ACK;
        I_ERR[gidx_q]   = T_ERR;
      end
      ST_LOCKED: begin
        T_LOCK = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign T_ADDR            = addr_a[gidx_q];
  assign T_DAT_ToTarget    = dat_a[gidx_q];
  assign T_SEL             = sel_a[gidx_q];
  assign I_DAT_ToInitiator = T_DAT_ToInitiator;
  assign Grant             = grant_q;
  assign DBG_STATE         = state_q;
  assign DBG_OUTSTANDING   = outst_q;

endmodule
